// File: rtl/rtc_timekeeper.sv
// Time-of-day counter: a prescaler turns the system clock into a one-cycle
// second tick that advances hh:mm:ss, with load, alarm, midnight and 12h view.
module rtc_timekeeper #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] ld_hours,
  input  logic [5:0] ld_minutes,
  input  logic [5:0] ld_seconds,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       mode_12h,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [3:0] disp_hours,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_pulse,
  output logic       alarm_hit,
  output logic       load_err
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hrs_q, hrs_d;
  logic          sec_tick_q, sec_tick_d, day_pulse_q, day_pulse_d;
  logic          alarm_hit_q, alarm_hit_d, load_err_q, load_err_d;

  logic          tick, ld_ok;
  logic [5:0]    sec_n, min_n;
  logic [4:0]    hrs_n;

  always_comb begin
    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hrs_d       = hrs_q;
    sec_tick_d  = 1'b0;
    day_pulse_d = 1'b0;
    alarm_hit_d = 1'b0;
    load_err_d  = 1'b0;

    tick  = run && (presc_q == PRE_MAX);
    ld_ok = (ld_hours < 5'd24) && (ld_minutes < 6'd60) && (ld_seconds < 6'd60);

    // Carry chain for the candidate next second.
    sec_n = sec_q + 6'd1;
    min_n = min_q;
    hrs_n = hrs_q;
    if (sec_q == 6'd59) begin
      sec_n = 6'd0;
      min_n = min_q + 6'd1;
      if (min_q == 6'd59) begin
        min_n = 6'd0;
        hrs_n = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
      end
    end

    if (load) begin
      // Load wins over a coincident tick; a rejected load freezes everything.
      if (ld_ok) begin
        sec_d   = ld_seconds;
        min_d   = ld_minutes;
        hrs_d   = ld_hours;
        presc_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      presc_d     = '0;
      sec_d       = sec_n;
      min_d       = min_n;
      hrs_d       = hrs_n;
      sec_tick_d  = 1'b1;
      day_pulse_d = (sec_n == 6'd0) && (min_n == 6'd0) && (hrs_n == 5'd0);
      alarm_hit_d = alarm_en && (sec_n == 6'd0) && (min_n == alarm_minutes)
                    && (hrs_n == alarm_hours);
    end else if (run) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hrs_q       <= '0;
      sec_tick_q  <= 1'b0;
      day_pulse_q <= 1'b0;
      alarm_hit_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hrs_q       <= hrs_d;
      sec_tick_q  <= sec_tick_d;
      day_pulse_q <= day_pulse_d;
      alarm_hit_q <= alarm_hit_d;
      load_err_q  <= load_err_d;
    end
  end

  logic [4:0] hrs_12;

  always_comb begin
    hrs_12 = hrs_q;
    if (hrs_q == 5'd0 || hrs_q == 5'd12) hrs_12 = 5'd12;
    else if (hrs_q > 5'd12)              hrs_12 = hrs_q - 5'd12;
    disp_hours = mode_12h ? hrs_12[3:0] : hrs_q[3:0];
    pm         = (hrs_q >= 5'd12);
  end

  assign seconds   = sec_q;
  assign minutes   = min_q;
  assign hours     = hrs_q;
  assign sec_tick  = sec_tick_q;
  assign day_pulse = day_pulse_q;
  assign alarm_hit = alarm_hit_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: directed steps plus random traffic, checked each
// cycle against a seconds-of-day reference model.
module tb_rtc_timekeeper;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0, load = 1'b0, alarm_en = 1'b0, mode_12h = 1'b0;
  logic [4:0] ld_hours = '0, alarm_hours = '0;
  logic [5:0] ld_minutes = '0, ld_seconds = '0, alarm_minutes = '0;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [3:0] disp_hours;
  logic       pm, sec_tick, day_pulse, alarm_hit, load_err;

  rtc_timekeeper #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load),
    .ld_hours(ld_hours), .ld_minutes(ld_minutes), .ld_seconds(ld_seconds),
    .alarm_en(alarm_en), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .mode_12h(mode_12h), .seconds(seconds), .minutes(minutes), .hours(hours),
    .disp_hours(disp_hours), .pm(pm), .sec_tick(sec_tick), .day_pulse(day_pulse),
    .alarm_hit(alarm_hit), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int tod = 0, pre = 0;
  bit m_tick = 0, m_day = 0, m_alarm = 0, m_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tod = 0; pre = 0; m_tick = 0; m_day = 0; m_alarm = 0; m_err = 0;
  endtask

  task automatic model_edge();
    m_tick = 0; m_day = 0; m_alarm = 0; m_err = 0;
    if (!rst_n) begin
      model_reset();
    end else if (load) begin
      if (ld_hours < 24 && ld_minutes < 60 && ld_seconds < 60) begin
        tod = ld_hours * 3600 + ld_minutes * 60 + ld_seconds;
        pre = 0;
      end else begin
        m_err = 1;
      end
    end else if (run) begin
      if (pre == DIV - 1) begin
        pre = 0;
        tod = (tod + 1) % 86400;
        m_tick = 1;
        m_day = (tod == 0);
        m_alarm = alarm_en && alarm_hours < 24 && alarm_minutes < 60 &&
                  tod == alarm_hours * 3600 + alarm_minutes * 60;
      end else begin
        pre++;
      end
    end
  endtask

  task automatic check_all();
    int h, dh;
    h = tod / 3600;
    if (mode_12h) dh = (h % 12 == 0) ? 12 : h % 12;
    else          dh = h % 16;
    chk("seconds", seconds, tod % 60);
    chk("minutes", minutes, (tod / 60) % 60);
    chk("hours", hours, h);
    chk("disp_hours", disp_hours, dh);
    chk("pm", pm, int'(h >= 12));
    chk("sec_tick", sec_tick, m_tick);
    chk("day_pulse", day_pulse, m_day);
    chk("alarm_hit", alarm_hit, m_alarm);
    chk("load_err", load_err, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_load(input int h, input int m, input int s);
    ld_hours = 5'(h); ld_minutes = 6'(m); ld_seconds = 6'(s);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    mode_12h = 1'b1;
    #1;
    chk("reset_disp12", disp_hours, 12);
    chk("reset_pm", pm, 0);
    step();
    rst_n = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Asynchronous reset in the middle of a second.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    run = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("rst_first_tick", sec_tick, int'(i == 4));
    end
    chk("rst_seconds", seconds, 1);

    // Midnight wrap.
    mode_12h = 1'b0;
    do_load(23, 59, 58);
    for (int i = 0; i < 4; i++) step();
    chk("mid_sec59", seconds, 59);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("mid_day", day_pulse, int'(i == 4));
    end
    chk("mid_hours0", hours, 0);
    chk("mid_tick", sec_tick, 1);
    step();
    chk("mid_day_once", day_pulse, 0);

    // Rejected loads leave the time alone.
    do_load(24, 0, 0);
    chk("err_h24", load_err, 1);
    do_load(12, 60, 0);
    chk("err_m60", load_err, 1);
    chk("err_time_kept", hours, 0);
    step();
    chk("err_pulse_once", load_err, 0);

    // Valid load on the same edge as a tick.
    for (int i = 0; i < 2 * DIV && pre != DIV - 1; i++) step();
    chk("pre_at_max", pre, DIV - 1);
    do_load(12, 34, 56);
    chk("coinc_no_tick", sec_tick, 0);
    chk("coinc_sec", seconds, 56);
    for (int i = 1; i <= DIV; i++) begin
      step();
      chk("coinc_next_tick", sec_tick, int'(i == DIV));
    end

    // Alarm.
    alarm_hours = 5'd7; alarm_minutes = 6'd30; alarm_en = 1'b1;
    do_load(7, 29, 59);
    for (int i = 0; i < DIV; i++) step();
    chk("alarm_hit_on", alarm_hit, 1);
    alarm_en = 1'b0;
    do_load(7, 29, 59);
    for (int i = 0; i < DIV; i++) step();
    chk("alarm_hit_off", alarm_hit, 0);
    alarm_en = 1'b1;
    do_load(7, 30, 0);
    chk("alarm_on_load", alarm_hit, 0);

    // Pause with the prescaler at 2.
    do_load(1, 2, 3);
    step(); step();
    chk("pause_pre2", pre, 2);
    run = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("pause_frozen", seconds, 3);
    run = 1'b1;
    step();
    chk("resume_no_tick", sec_tick, 0);
    step();
    chk("resume_tick", sec_tick, 1);
    chk("resume_sec", seconds, 4);

    // 12-hour view.
    mode_12h = 1'b1;
    run = 1'b0;
    do_load(0, 0, 0);  chk("h12_0", disp_hours, 12); chk("pm_0", pm, 0);
    do_load(11, 0, 0); chk("h12_11", disp_hours, 11); chk("pm_11", pm, 0);
    do_load(12, 0, 0); chk("h12_12", disp_hours, 12); chk("pm_12", pm, 1);
    do_load(23, 0, 0); chk("h12_23", disp_hours, 11); chk("pm_23", pm, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      run = ($urandom_range(0, 7) != 0);
      mode_12h = $urandom_range(0, 1);
      alarm_en = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) begin
        alarm_hours = 5'($urandom_range(0, 25));
        alarm_minutes = 6'($urandom_range(0, 61));
      end
      if ($urandom_range(0, 19) == 0) begin
        ld_hours = 5'($urandom_range(0, 25));
        ld_minutes = 6'($urandom_range(55, 63));
        ld_seconds = 6'($urandom_range(50, 63));
        load = 1'b1;
      end
      step();
      load = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised single-clock time-of-day counter. An internal prescaler divides the system clock into a one-cycle tick, replacing any derived clock. The tick drives an hh:mm:ss counter with run/pause, validated time load, a minute-resolution alarm, a midnight pulse and a 12/24-hour display view. It sits between the system clock domain and the display/alarm logic.

## Interface
- `DIV`, 50_000_000, system clock cycles per second; legal range ≥ 1. Prescaler width is max(1, clog2(DIV)).
- `clk` input 1: system clock; all flops are on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `run` input 1: 1 = prescaler counts, 0 = prescaler and time hold.
- `load` input 1: one-cycle request to write time from `ld_*`.
- `ld_hours` input 5, `ld_minutes` input 6, `ld_seconds` input 6: load values, 24-hour format.
- `alarm_en` input 1: enables `alarm_hit`.
- `alarm_hours` input 5, `alarm_minutes` input 6: alarm time, 24-hour format.
- `mode_12h` input 1: selects the display format on `disp_hours`/`pm`.
- `seconds` output 6, `minutes` output 6, `hours` output 5: registered time, 24-hour format.
- `disp_hours` output 4, `pm` output 1: display hour, combinational from `hours`.
- `sec_tick` output 1: registered, one cycle per time advance.
- `day_pulse` output 1: registered, one cycle on the 23:59:59→00:00:00 advance.
- `alarm_hit` output 1: registered one-cycle pulse.
- `load_err` output 1: registered one-cycle pulse.

## Operation
- Reset (`rst_n`=0, asynchronous):
  - prescaler, `seconds`, `minutes`, `hours` = 0.
  - `sec_tick`, `day_pulse`, `alarm_hit`, `load_err` = 0.
  - `disp_hours` = 12 when `mode_12h`=1, 0 when `mode_12h`=0; `pm` = 0.
- Prescaler:
  - With `run`=1 it counts 0..DIV-1. At DIV-1 it wraps to 0 and a tick occurs on that edge.
  - With `run`=0 it holds its value. No partial-second loss across a pause.
- Advance on tick:
  - seconds 59→0 carries into minutes; minutes 59→0 carries into hours; hours 23→0.
  - `day_pulse` fires on the full 23:59:59→00:00:00 wrap.
- Load (edge where `load`=1), priority over tick:
  - Valid iff `ld_hours`<24, `ld_minutes`<60 and `ld_seconds`<60.
  - Valid: time registers take the `ld_*` values and the prescaler clears to 0. Any coincident tick is discarded; no `sec_tick`, `day_pulse` or `alarm_hit` is produced.
  - Invalid: time and prescaler are unchanged (including any coincident tick), and `load_err`=1 next cycle.
  - A load never produces `alarm_hit`.
- Alarm:
  - `alarm_hit`=1 when a tick advance produces new time = `alarm_hours`:`alarm_minutes`:00 and `alarm_en`=1 at that edge.
  - Out-of-range alarm values never match.
- Display:
  - `mode_12h`=0: `disp_hours` = `hours`[3:0], valid for 0..15 only (upper 16..23 is not representable; consumers use `hours` in 24-hour mode).
  - `mode_12h`=1: `disp_hours` = 12 when `hours` is 0 or 12, otherwise `hours` mod 12.
  - `pm` = (`hours` ≥ 12) in both modes.

## Timing
- Tick latency: a tick at edge N updates the time at edge N. `sec_tick`, `day_pulse` and `alarm_hit` are high during cycle N..N+1, coincident with the new time.
- Second period: with `run` held at 1 and no load, `sec_tick` pulses exactly every DIV cycles. DIV=1 gives a pulse every cycle.
- Load latency: the new time is visible in the cycle after the `load` edge. The first tick after a valid load follows DIV cycles later.
- `load_err` is asserted in the cycle after the invalid `load` edge.
- Pulses: every pulse lasts exactly one cycle. Back-to-back loads each produce their own response.
- Reset mid-operation: all state clears immediately. The first tick comes DIV cycles after `rst_n` rises, with `run`=1.

## Test plan
- Reset: apply reset mid-count, then release with `run`=1 and DIV=4. Required: outputs read 0 throughout reset; first `sec_tick` on the 4th edge after release; `seconds`=1 at that point.
- Midnight wrap: DIV=4, load 23:59:58, then run. Required: after 4 cycles, 23:59:59; after 8 cycles, 00:00:00 with `day_pulse`=1 for one cycle and `sec_tick`=1.
- Load validity:
  - load 24:00:00 → `load_err` pulse, time unchanged.
  - load 12:60:00 → `load_err` pulse, time unchanged.
  - load 12:34:56 coincident with a tick → time 12:34:56, no `sec_tick`, prescaler 0.
- Alarm: alarm 07:30, `alarm_en`=1, load 07:29:59. Required: the next tick gives 07:30:00 with `alarm_hit`=1. Repeat with `alarm_en`=0 → no pulse. Loading 07:30:00 directly → no pulse.
- Pause: DIV=4, drop `run` at prescaler=2 for 10 cycles, then raise it. Required: time frozen during the pause; next tick 2 cycles after `run` rises (at prescaler=3 then wrap).
- 12-hour view, with `mode_12h`=1:
  - `hours`=0 → 12/`pm`0.
  - `hours`=11 → 11/`pm`0.
  - `hours`=12 → 12/`pm`1.
  - `hours`=23 → 11/`pm`1.
